// File: rtl/lpc_host_io.sv
// LPC host for single-byte I/O read/write cycles.
// Takes one request on a valid/ready port, runs the whole LPC frame and
// returns read data plus a status bit on a one-cycle response strobe.
// Every bus output is registered from the next state, so the value that
// belongs to a state is held for that state's whole clock period.
module lpc_host_io #(
  parameter int SHORT_TIMEOUT = 8,
  parameter int LONG_TIMEOUT  = 1024
) (
  input  logic        lpc_clk,
  input  logic        lpc_rst,
  inout  wire  [3:0]  lpc_data,
  output logic        lpc_frame,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error
);

  localparam int CW = $clog2(LONG_TIMEOUT + 1);
  localparam logic [CW-1:0] SHORT_LIM = CW'(SHORT_TIMEOUT);
  localparam logic [CW-1:0] LONG_LIM  = CW'(LONG_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CTDIR, S_ADDR, S_WDATA0, S_WDATA1, S_HTAR0, S_HTAR1,
    S_SYNC, S_RDATA0, S_RDATA1, S_PTAR0, S_PTAR1, S_ABORT, S_RECOVER
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    nib_q, nib_d;       // address nibble index, reused as ABORT length
  logic [CW-1:0] cnt_q, cnt_d;       // consecutive SYNC wait cycles
  logic          err_q, err_d;       // error SYNC seen in this frame
  logic          write_q, write_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rbuf_q, rbuf_d;     // read nibbles as they arrive
  logic [7:0]    rdata_q, rdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_error_q, rsp_error_d;
  logic          frame_q, frame_d;
  logic          lad_oe_q, lad_oe_d;
  logic [3:0]    lad_q, lad_d;
  logic          ready_q, ready_d;
  logic [CW-1:0] cnt_inc;

  assign lpc_data  = lad_oe_q ? lad_q : 4'bz;
  assign lpc_frame = frame_q;
  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_error = rsp_error_q;
  assign cnt_inc   = cnt_q + 1'b1;

  // State and registered bus/response outputs; reset releases the bus at once.
  always_ff @(posedge lpc_clk or posedge lpc_rst) begin
    if (lpc_rst) begin
      state_q     <= S_IDLE;
      nib_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      frame_q     <= 1'b1;
      lad_oe_q    <= 1'b0;
      lad_q       <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      nib_q       <= nib_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      frame_q     <= frame_d;
      lad_oe_q    <= lad_oe_d;
      lad_q       <= lad_d;
      ready_q     <= ready_d;
    end
  end

  // Next state, then the bus values that belong to that next state.
  always_comb begin
    state_d     = state_q;
    nib_d       = nib_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = rsp_error_q;
    frame_d     = 1'b1;
    lad_oe_d    = 1'b0;
    lad_d       = 4'h0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_START;
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = 1'b0;
        end
      end
      S_START: state_d = S_CTDIR;
      S_CTDIR: begin
        state_d = S_ADDR;
        nib_d   = 2'd0;
      end
      S_ADDR: begin
        nib_d = nib_q + 2'd1;
        if (nib_q == 2'd3) state_d = write_q ? S_WDATA0 : S_HTAR0;
      end
      S_WDATA0: state_d = S_WDATA1;
      S_WDATA1: state_d = S_HTAR0;
      S_HTAR0:  state_d = S_HTAR1;
      S_HTAR1: begin
        state_d = S_SYNC;
        cnt_d   = '0;
      end
      S_SYNC: begin
        case (lpc_data)
          4'h0: state_d = write_q ? S_PTAR0 : S_RDATA0;
          4'hA: begin
            err_d   = 1'b1;
            state_d = write_q ? S_PTAR0 : S_RDATA0;
          end
          4'h6: begin
            cnt_d = cnt_inc;
            if (cnt_inc >= LONG_LIM) begin
              state_d = S_ABORT;
              nib_d   = 2'd0;
            end
          end
          // short wait, absent target (F) and anything unrecognised
          default: begin
            cnt_d = cnt_inc;
            if (cnt_inc >= SHORT_LIM) begin
              state_d = S_ABORT;
              nib_d   = 2'd0;
            end
          end
        endcase
      end
      S_RDATA0: begin
        rbuf_d[3:0] = lpc_data;
        state_d     = S_RDATA1;
      end
      S_RDATA1: begin
        rbuf_d[7:4] = lpc_data;
        state_d     = S_PTAR0;
      end
      S_PTAR0: state_d = S_PTAR1;
      S_PTAR1: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_error_d = err_q;
        if (!write_q) rdata_d = rbuf_q;
      end
      S_ABORT: begin
        nib_d = nib_q + 2'd1;
        if (nib_q == 2'd3) state_d = S_RECOVER;
      end
      S_RECOVER: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_error_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: begin
        frame_d  = 1'b0;
        lad_oe_d = 1'b1;
        lad_d    = 4'h0;
      end
      S_CTDIR: begin
        lad_oe_d = 1'b1;
        lad_d    = write_q ? 4'h2 : 4'h0;
      end
      S_ADDR: begin
        lad_oe_d = 1'b1;
        case (nib_d)
          2'd0:    lad_d = addr_q[15:12];
          2'd1:    lad_d = addr_q[11:8];
          2'd2:    lad_d = addr_q[7:4];
          default: lad_d = addr_q[3:0];
        endcase
      end
      S_WDATA0: begin
        lad_oe_d = 1'b1;
        lad_d    = wdata_q[3:0];
      end
      S_WDATA1: begin
        lad_oe_d = 1'b1;
        lad_d    = wdata_q[7:4];
      end
      S_HTAR0: begin
        lad_oe_d = 1'b1;
        lad_d    = 4'hF;
      end
      S_ABORT: begin
        frame_d  = 1'b0;
        lad_oe_d = 1'b1;
        lad_d    = 4'hF;
      end
      default: ;
    endcase

    ready_d = (state_d == S_IDLE);
  end

endmodule

// File: doc/lpc_host_io.md
Name: lpc_host_io

Overview:
- LPC host (initiator) for 8-bit I/O read and I/O write cycles on the LPC bus; the counterpart of the codebase's LPC peripheral decoders.
- Accepts single-byte requests on a valid/ready interface and runs the full LPC frame: START, CTDIR, address, data, turnaround, SYNC, turnaround.
- Returns read data and completion status on a response strobe.
- Used as the bench/bridge master that drives UART-style peripherals (e.g. THR at 0x3F8, LSR at 0x3FD).

Parameters:
- SHORT_TIMEOUT, 8: max consecutive SYNC cycles with no valid SYNC nibble (F or unrecognised) before abort.
- LONG_TIMEOUT, 1024: max consecutive long-wait (6) SYNC cycles before abort.

Ports:
- lpc_clk  input  1  LPC clock; all logic on rising edge.
- lpc_rst  input  1  asynchronous, active-high reset.
- lpc_data  inout  4  LAD[3:0]; driven by host or tristated.
- lpc_frame  output  1  LFRAME#, active low.
- req_valid  input  1  request present.
- req_ready  output  1  host can accept a request (IDLE only).
- req_write  input  1  1 = I/O write, 0 = I/O read.
- req_addr  input  16  I/O address.
- req_wdata  input  8  write byte.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  8  read byte; valid with rsp_valid for reads; held until next response.
- rsp_error  output  1  with rsp_valid: 1 = SYNC error (A) or timeout abort.

Behaviour:
- Reset (async, immediate): state IDLE; lpc_frame=1; lpc_data tristated; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_error=0; timeout counter=0. Reset mid-frame releases the bus immediately; no response is produced for the aborted request.
- All bus outputs are registered. The value driven in a state is visible for that whole clock period. The peripheral samples it on the closing edge.
- Handshake: request accepted on a rising edge with req_valid & req_ready. req_write, req_addr and req_wdata are captured. req_ready drops in the next cycle and stays low until the cycle after the return to IDLE.
- Per-state bus activity, in order:
  - IDLE: frame=1, LAD tristated.
  - START: frame=0, LAD=0000.
  - CTDIR: frame=1, LAD=0000 (read) or 0010 (write).
  - ADDR: 4 cycles, LAD = addr[15:12], [11:8], [7:4], [3:0]; 2-bit nibble counter.
  - WDATA0: writes only, LAD=wdata[3:0].
  - WDATA1: writes only, LAD=wdata[7:4].
  - HTAR0: LAD=1111.
  - HTAR1: LAD tristated; host stops driving.
  - SYNC: tristated; sample LAD every edge.
    - 0000: ready. Go to RDATA0 (read) or PTAR0 (write).
    - 0101: short wait; increment counter; abort when counter reaches SHORT_TIMEOUT.
    - 0110: long wait; increment counter; abort when counter reaches LONG_TIMEOUT.
    - 1010: error. Set error flag and proceed as for 0000.
    - Any other nibble (incl. 1111 from an absent target): same as 0101 for timeout.
    - Counter clears on entry to SYNC.
  - RDATA0 / RDATA1: capture rdata[3:0], then rdata[7:4].
  - PTAR0 / PTAR1: peripheral turnaround; host keeps LAD tristated for 2 cycles.
  - From PTAR1, return to IDLE, assert rsp_valid for 1 cycle, and set rsp_error = error flag.
- Minimum frame length: 13 cycles from START to end of PTAR1 for both reads and writes with immediate SYNC 0.
- Abort (timeout):
  - ABORT state holds frame=0 and LAD=1111 for exactly 4 cycles.
  - Then 1 RECOVER cycle with frame=1 and LAD tristated.
  - Then IDLE with rsp_valid=1, rsp_error=1, and rsp_rdata unchanged.
- rsp_rdata updates only on successful or error-SYNC reads; it is unchanged for writes and aborts.
- Back-to-back: a new request may be accepted in the first IDLE cycle; START follows on the next edge (1 idle cycle with frame=1 between frames).
- The host never drives LAD in HTAR1, SYNC, RDATA*, or PTAR*. Bus contention in those states is a verification failure.

Test Plan:
- Write 0x03F8 data 0x41, bench peripheral returns SYNC 0 in the first SYNC cycle. Required:
  - LAD sequence 0,2,0,3,F,8,1,4,F,Z.
  - lpc_frame low only in START.
  - rsp_valid 13 cycles after START, rsp_error=0.
- Read 0x03FD, peripheral returns SYNC 0 then data 0x20. Required:
  - LAD 0,0,0,3,F,D,F,Z.
  - rsp_rdata=0x20, rsp_error=0.
- Read with SYNC 5,5,5 then 0, data 0xA5. Required: frame is 3 cycles longer than minimum, rsp_rdata=0xA5, rsp_error=0.
- Write with SYNC 1010. Required: rsp_error=1, rsp_rdata unchanged. A read with SYNC A and data 0x3C returns rsp_rdata=0x3C, rsp_error=1.
- No peripheral (LAD pulled to F). Required:
  - After 8 SYNC cycles, lpc_frame=0 with LAD=F for 4 cycles, then 1 recover cycle.
  - Then rsp_valid with rsp_error=1.
  - The next queued request starts cleanly.
- Assert lpc_rst during ADDR nibble 2. Required:
  - Same cycle: lpc_frame=1 and LAD=Z.
  - After release, req_ready=1, no rsp_valid.
  - A following write of 0x41 completes normally.
